// File: rtl/mc_control_if.sv
// mc_control_if: IR fields, ALU flag, memory handshake and datapath control bundle
interface mc_control_if #(parameter int ALU_CTRL_W = 4);
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic funct7_5;
  logic zero;
  logic mem_ready;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic ir_write;
  logic pc_write;
  logic reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic illegal_instr;
  modport master (
    input opcode, funct3, funct7_5, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
    output alu_src_a, alu_src_b, result_src, alu_control, illegal_instr
  );
  modport slave (
    output opcode, funct3, funct7_5, zero, mem_ready,
    input mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
    input alu_src_a, alu_src_b, result_src, alu_control, illegal_instr
  );
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle RV32 control sequencer with single-port memory handshake
module mc_control_fsm #(
  parameter int ALU_CTRL_W = 4,
  parameter bit TRAP_STICKY = 1'b1
) (
  input logic clk,
  input logic rst,
  mc_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
  } state_t;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(4'b0000);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(4'b0001);
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(4'b0010);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(4'b0110);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(4'b0111);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  state_t state_q, state_d, dec_next;
  logic exec_ok;
  logic [ALU_CTRL_W-1:0] exec_op;
  logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_instr;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [ALU_CTRL_W-1:0] alu_control;
  assign dec_next = (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) ? MEMADR :
                    bus.opcode == OP_R      ? EXECR  :
                    bus.opcode == OP_I      ? EXECI  :
                    bus.opcode == OP_BRANCH ? BRANCH :
                    bus.opcode == OP_JAL    ? JAL    : TRAP;
  assign exec_ok = bus.funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};
  // SUB is only reachable from R-type; ADDI ignores IR[30]
  assign exec_op = bus.funct3 == 3'b000 ? ((state_q == EXECR && bus.funct7_5) ? ALU_SUB : ALU_ADD) :
                   bus.funct3 == 3'b010 ? ALU_SLT :
                   bus.funct3 == 3'b110 ? ALU_OR  :
                   bus.funct3 == 3'b111 ? ALU_AND : ALU_ADD;
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else state_q <= state_d;
  end
  // Defaults double as the reset-time output values, so rst simply skips the decode
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_write = 1'b0;
    adr_src = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    result_src = 2'b00;
    alu_control = ALU_ADD;
    illegal_instr = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          alu_src_b = 2'b10;
          result_src = 2'b10;
          ir_write = bus.mem_ready;
          pc_write = bus.mem_ready;
          state_d = bus.mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          state_d = dec_next;
        end
        MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          state_d = bus.opcode[5] ? MEMWRITE : MEMREAD;
        end
        MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          state_d = bus.mem_ready ? MEMWB : MEMREAD;
        end
        MEMWB: begin
          reg_write = 1'b1;
          result_src = 2'b01;
          state_d = FETCH;
        end
        MEMWRITE: begin
          mem_req = 1'b1;
          mem_write = 1'b1;
          adr_src = 1'b1;
          state_d = bus.mem_ready ? FETCH : MEMWRITE;
        end
        EXECR, EXECI: begin
          alu_src_a = 2'b10;
          alu_src_b = state_q == EXECI ? 2'b01 : 2'b00;
          alu_control = exec_op;
          state_d = exec_ok ? ALUWB : TRAP;
        end
        ALUWB: begin
          reg_write = 1'b1;
          state_d = FETCH;
        end
        BRANCH: begin
          alu_src_a = 2'b10;
          alu_control = ALU_SUB;
          pc_write = (bus.funct3 == 3'b000 && bus.zero) || (bus.funct3 == 3'b001 && !bus.zero);
          state_d = bus.funct3[2:1] == 2'b00 ? FETCH : TRAP;
        end
        JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write = 1'b1;
          state_d = ALUWB;
        end
        TRAP: begin
          illegal_instr = 1'b1;
          state_d = TRAP_STICKY ? TRAP : FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end
  assign bus.mem_req = mem_req;
  assign bus.mem_write = mem_write;
  assign bus.adr_src = adr_src;
  assign bus.ir_write = ir_write;
  assign bus.pc_write = pc_write;
  assign bus.reg_write = reg_write;
  assign bus.alu_src_a = alu_src_a;
  assign bus.alu_src_b = alu_src_b;
  assign bus.result_src = result_src;
  assign bus.alu_control = alu_control;
  assign bus.illegal_instr = illegal_instr;
endmodule
